// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - register-file read-port arbiter that stalls the CPU and streams r0..rN-1 out
module regfile_dump_ctrl #(
    parameter int NUM_REGS    = 13,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int AUTO_CYCLES = 25
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dump_req_i,
    input  logic [ADDR_W-1:0] cpu_rs_addr_i,
    output logic [DATA_W-1:0] cpu_rs_data_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              cpu_stall_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [31:0]       AUTO_LIM = 32'(AUTO_CYCLES);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       cycle_cnt;
    logic              auto_fired;
    logic              auto_hit;
    logic              trigger;
    logic              beat_ok;
    logic              at_last;

    // The auto trigger is consumed even when the FSM is busy, so it can fire at most once per reset.
    assign auto_hit = (AUTO_CYCLES != 0) && (cycle_cnt == AUTO_LIM - 32'd1) && !auto_fired;
    assign trigger  = dump_req_i || auto_hit;
    assign beat_ok  = (state == S_SEND) && dump_ready_i;
    assign at_last  = (idx == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            idx        <= '0;
            data_q     <= '0;
            cycle_cnt  <= '0;
            auto_fired <= 1'b0;
        end else begin
            state <= state_nx;
            if (cycle_cnt != AUTO_LIM) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (auto_hit) begin
                auto_fired <= 1'b1;
            end
            case (state)
                S_IDLE:  if (trigger) idx <= '0;
                S_READ:  data_q <= rf_data_i;
                S_SEND:  if (beat_ok && !at_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (trigger) state_nx = S_STALL;
            S_STALL: state_nx = S_READ;
            S_READ:  state_nx = S_SEND;
            S_SEND:  if (beat_ok) state_nx = at_last ? S_DONE : S_READ;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outside IDLE the CPU sees zeros and the RF port belongs to the dump sequencer.
    assign cpu_stall_o   = (state != S_IDLE);
    assign rf_addr_o     = (state == S_IDLE) ? cpu_rs_addr_i : idx;
    assign cpu_rs_data_o = (state == S_IDLE) ? rf_data_i : '0;
    assign dump_valid_o  = (state == S_SEND);
    assign dump_idx_o    = dump_valid_o ? idx : '0;
    assign dump_data_o   = dump_valid_o ? data_q : '0;
    assign dump_last_o   = dump_valid_o && at_last;
    assign done_o        = (state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - directed self-checking bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dump_req_i;
    logic [4:0]  cpu_rs_addr_i;
    logic [31:0] cpu_rs_data_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic        cpu_stall_o;
    logic        dump_valid_o;
    logic        dump_ready_i;
    logic [4:0]  dump_idx_o;
    logic [31:0] dump_data_o;
    logic        dump_last_o;
    logic        done_o;

    logic [31:0] rf_mem [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clk_i = ~clk_i;

    assign rf_data_i = rf_mem[rf_addr_o];

    regfile_dump_ctrl #(
        .NUM_REGS(13), .ADDR_W(5), .DATA_W(32), .AUTO_CYCLES(25)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dump_req_i(dump_req_i),
        .cpu_rs_addr_i(cpu_rs_addr_i), .cpu_rs_data_o(cpu_rs_data_o),
        .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
        .cpu_stall_o(cpu_stall_o), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o),
        .dump_data_o(dump_data_o), .dump_last_o(dump_last_o), .done_o(done_o)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [4:0]  addr;
        logic        ready;
        logic        exp_stall;
        logic [4:0]  exp_rf_addr;
        logic [31:0] exp_cpu_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(name, {63'd0, cpu_stall_o}, 64'd0);
        end
    endtask

    task automatic pulse_req(input string name);
        dump_req_i = 1'b1;
        tick();
        dump_req_i = 1'b0;
        chk(name, {63'd0, cpu_stall_o}, 64'd1);
    endtask

    // Entered with the first stall cycle already sampled; follows the dump until stall drops.
    task automatic run_dump(input string name, input int hold_idx, input int hold_len,
                            input bit noise, input int exp_stall);
        int stall_cnt = 0;
        int beat = 0;
        int done_cnt = 0;
        int done_at = 0;
        int first_valid = 0;
        int low = 0;
        int cycles = 0;
        while (cycles < 200) begin
            if (!cpu_stall_o) break;
            stall_cnt++;
            if (done_o) begin
                done_cnt++;
                done_at = stall_cnt;
            end
            if (dump_valid_o) begin
                if (first_valid == 0) first_valid = stall_cnt;
                chk({name, "_idx"}, 64'(dump_idx_o), 64'(beat));
                chk({name, "_data"}, 64'(dump_data_o), 64'(3 * beat));
                chk({name, "_last"}, {63'd0, dump_last_o}, {63'd0, beat == 12});
            end else begin
                chk({name, "_last_nv"}, {63'd0, dump_last_o}, 64'd0);
            end
            if (dump_valid_o && beat == hold_idx && low < hold_len) begin
                dump_ready_i = 1'b0;
                low++;
            end else begin
                dump_ready_i = 1'b1;
            end
            if (dump_valid_o && dump_ready_i) beat++;
            dump_req_i = noise ? cycles[0] : 1'b0;
            tick();
            cycles++;
        end
        dump_req_i   = 1'b0;
        dump_ready_i = 1'b1;
        chk({name, "_ended"}, {63'd0, cpu_stall_o}, 64'd0);
        chk({name, "_beats"}, 64'(beat), 64'd13);
        chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        chk({name, "_first_valid"}, 64'(first_valid), 64'd3);
        chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({name, "_done_at"}, 64'(done_at), 64'(exp_stall));
        chk({name, "_hold_cycles"}, 64'(low), 64'(hold_len));
        chk({name, "_idle_valid"}, {63'd0, dump_valid_o}, 64'd0);
        chk({name, "_idle_done"}, {63'd0, done_o}, 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(3 * i);

        vecs[0] = '{1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  32'd21};
        vecs[1] = '{1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 5'd7,  32'd21};
        vecs[2] = '{1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 5'd7,  32'd21};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 5'd0,  32'd0};
        vecs[4] = '{1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 5'd31, 32'd93};

        rst_i = 1'b0;
        dump_req_i = 1'b0;
        cpu_rs_addr_i = 5'd7;
        dump_ready_i = 1'b1;

        // Reset held: no dump activity, passthrough live.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk_i);
            rst_i = vecs[v].rst;
            dump_req_i = vecs[v].req;
            cpu_rs_addr_i = vecs[v].addr;
            dump_ready_i = vecs[v].ready;
            tick();
            chk($sformatf("v%0d_stall", v), {63'd0, cpu_stall_o}, {63'd0, vecs[v].exp_stall});
            chk($sformatf("v%0d_valid", v), {63'd0, dump_valid_o}, 64'd0);
            chk($sformatf("v%0d_last", v), {63'd0, dump_last_o}, 64'd0);
            chk($sformatf("v%0d_done", v), {63'd0, done_o}, 64'd0);
            chk($sformatf("v%0d_idx", v), 64'(dump_idx_o), 64'd0);
            chk($sformatf("v%0d_data", v), 64'(dump_data_o), 64'd0);
            chk($sformatf("v%0d_rf_addr", v), 64'(rf_addr_o), 64'(vecs[v].exp_rf_addr));
            chk($sformatf("v%0d_cpu_data", v), 64'(cpu_rs_data_o), 64'(vecs[v].exp_cpu_data));
        end

        // Auto trigger: stall first seen after the 25th edge with reset released.
        rst_i = 1'b1;
        dump_req_i = 1'b0;
        dump_ready_i = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_stall_o) begin
                n = i;
                break;
            end
        end
        chk("auto_start_edge", 64'(n), 64'd25);
        run_dump("auto", -1, 0, 1'b0, 28);
        idle_check("auto_once", 40);

        pulse_req("req_latency");
        run_dump("basic", -1, 0, 1'b0, 28);

        pulse_req("hold_latency");
        run_dump("hold", 4, 5, 1'b0, 33);

        pulse_req("noise_latency");
        run_dump("noise", -1, 0, 1'b1, 28);
        idle_check("req_not_queued", 10);
        cpu_rs_addr_i = 5'd9;
        #1;
        chk("pass_rf_addr", 64'(rf_addr_o), 64'd9);
        chk("pass_cpu_data", 64'(cpu_rs_data_o), 64'd27);

        // Reset in the middle of the beat for idx 6.
        pulse_req("abort_latency");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (dump_valid_o && dump_idx_o == 5'd6) begin
                n = 1;
                break;
            end
            tick();
        end
        chk("abort_reached_idx6", 64'(n), 64'd1);
        rst_i = 1'b0;
        tick();
        chk("abort_valid", {63'd0, dump_valid_o}, 64'd0);
        chk("abort_stall", {63'd0, cpu_stall_o}, 64'd0);
        chk("abort_done", {63'd0, done_o}, 64'd0);
        rst_i = 1'b1;
        pulse_req("restart_latency");
        run_dump("restart", -1, 0, 1'b0, 28);
        idle_check("auto_dropped", 40);

        // Request on the same edge as the auto trigger.
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk("pre_trigger_idle", {63'd0, cpu_stall_o}, 64'd0);
        end
        pulse_req("coincide_latency");
        run_dump("coincide", -1, 0, 1'b0, 28);
        idle_check("coincide_once", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
